// File: rtl/div_result_bcd.sv
// div_result_bcd: captures the 4-bit divider result and converts quotient and
// remainder into two-digit BCD with a fixed four-step double dabble. Digit
// outputs are registered and only change when a conversion finishes or on reset.
module div_result_bcd #(
    parameter logic [3:0] ERR_CODE = 4'hE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] Q,
    input  logic [3:0] R,
    input  logic       ERR,
    output logic       busy,
    output logic       done,
    output logic [3:0] q_tens,
    output logic [3:0] q_ones,
    output logic [3:0] r_tens,
    output logic [3:0] r_ones,
    output logic       err_out
);

    typedef enum logic [1:0] {
        StIdle,
        StConv,
        StFinish
    } state_t;

    state_t     state;
    logic [1:0] cnt;

    // Binary operands being shifted out MSB-first into the BCD accumulators.
    logic [3:0] q_bin;
    logic [3:0] r_bin;
    logic [7:0] q_bcd;
    logic [7:0] r_bcd;
    logic       err_cap;

    // Result of one double-dabble step: {next bcd[7:0], next bin[3:0]}.
    logic [11:0] q_step;
    logic [11:0] r_step;

    // One iteration: correct any nibble >= 5, then shift the {bcd, bin} pair left.
    function automatic logic [11:0] dd_step(input logic [7:0] bcd, input logic [3:0] bin);
        logic [7:0] adj;
        adj = bcd;
        if (adj[3:0] >= 4'd5) begin
            adj[3:0] = adj[3:0] + 4'd3;
        end
        if (adj[7:4] >= 4'd5) begin
            adj[7:4] = adj[7:4] + 4'd3;
        end
        return {adj[6:0], bin, 1'b0};
    endfunction

    // Next iteration for both operands, computed in parallel.
    always_comb begin
        q_step = dd_step(q_bcd, q_bin);
        r_step = dd_step(r_bcd, r_bin);
    end

    // Control FSM, conversion datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= StIdle;
            cnt     <= 2'd0;
            q_bin   <= 4'h0;
            r_bin   <= 4'h0;
            q_bcd   <= 8'h00;
            r_bcd   <= 8'h00;
            err_cap <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            q_tens  <= 4'h0;
            q_ones  <= 4'h0;
            r_tens  <= 4'h0;
            r_ones  <= 4'h0;
            err_out <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                StIdle: begin
                    if (start) begin
                        q_bin   <= Q;
                        r_bin   <= R;
                        err_cap <= ERR;
                        q_bcd   <= 8'h00;
                        r_bcd   <= 8'h00;
                        cnt     <= 2'd0;
                        busy    <= 1'b1;
                        state   <= StConv;
                    end
                end
                StConv: begin
                    q_bcd <= q_step[11:4];
                    q_bin <= q_step[3:0];
                    r_bcd <= r_step[11:4];
                    r_bin <= r_step[3:0];
                    cnt   <= cnt + 2'd1;
                    // Third iteration done here; the fourth happens in StFinish.
                    if (cnt == 2'd2) begin
                        state <= StFinish;
                    end
                end
                StFinish: begin
                    q_bcd <= q_step[11:4];
                    q_bin <= q_step[3:0];
                    r_bcd <= r_step[11:4];
                    r_bin <= r_step[3:0];
                    cnt   <= cnt + 2'd1;
                    if (err_cap) begin
                        q_tens <= ERR_CODE;
                        q_ones <= ERR_CODE;
                        r_tens <= ERR_CODE;
                        r_ones <= ERR_CODE;
                    end else begin
                        q_tens <= q_step[11:8];
                        q_ones <= q_step[7:4];
                        r_tens <= r_step[11:8];
                        r_ones <= r_step[7:4];
                    end
                    err_out <= err_cap;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state   <= StIdle;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_result_bcd.sv
// Testbench for div_result_bcd: a behavioural model (plain division/modulo and an
// edge countdown) is compared against the DUT on every cycle, plus directed
// conversions with hand-computed digit and latency expectations.
module tb_div_result_bcd;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] Q = 4'h0;
    logic [3:0] R = 4'h0;
    logic       ERR = 1'b0;
    logic       busy, done, err_out;
    logic [3:0] q_tens, q_ones, r_tens, r_ones;

    int n_pass = 0;
    int n_total = 0;
    bit chk_en = 1'b0;

    div_result_bcd dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .Q      (Q),
        .R      (R),
        .ERR    (ERR),
        .busy   (busy),
        .done   (done),
        .q_tens (q_tens),
        .q_ones (q_ones),
        .r_tens (r_tens),
        .r_ones (r_ones),
        .err_out(err_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: idle accepts start, then four more edges produce the result.
    logic       m_busy = 1'b0;
    logic       m_done = 1'b0;
    logic       m_err = 1'b0;
    logic [3:0] m_qt = 4'h0, m_qo = 4'h0, m_rt = 4'h0, m_ro = 4'h0;
    logic [3:0] m_q = 4'h0, m_r = 4'h0;
    logic       m_e = 1'b0;
    int         m_left = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_err  <= 1'b0;
            m_qt   <= 4'h0;
            m_qo   <= 4'h0;
            m_rt   <= 4'h0;
            m_ro   <= 4'h0;
            m_left <= 0;
        end else begin
            m_done <= 1'b0;
            if (!m_busy) begin
                if (start) begin
                    m_q    <= Q;
                    m_r    <= R;
                    m_e    <= ERR;
                    m_busy <= 1'b1;
                    m_left <= 3;
                end
            end else if (m_left == 0) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
                m_err  <= m_e;
                if (m_e) begin
                    m_qt <= 4'hE;
                    m_qo <= 4'hE;
                    m_rt <= 4'hE;
                    m_ro <= 4'hE;
                end else begin
                    m_qt <= m_q / 4'd10;
                    m_qo <= m_q % 4'd10;
                    m_rt <= m_r / 4'd10;
                    m_ro <= m_r % 4'd10;
                end
            end else begin
                m_left <= m_left - 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_busy", int'(busy), int'(m_busy));
            chk("cyc_done", int'(done), int'(m_done));
            chk("cyc_q_tens", int'(q_tens), int'(m_qt));
            chk("cyc_q_ones", int'(q_ones), int'(m_qo));
            chk("cyc_r_tens", int'(r_tens), int'(m_rt));
            chk("cyc_r_ones", int'(r_ones), int'(m_ro));
            chk("cyc_err_out", int'(err_out), int'(m_err));
        end
    end

    // Called at a negedge; returns at the negedge where done is seen.
    task automatic do_conv(input logic [3:0] q, input logic [3:0] r, input logic e,
                           input int eqt, input int eqo, input int ert, input int ero,
                           input int ee);
        int k;
        Q = q;
        R = r;
        ERR = e;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!done && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk("latency", k, 4);
        chk("q_tens", int'(q_tens), eqt);
        chk("q_ones", int'(q_ones), eqo);
        chk("r_tens", int'(r_tens), ert);
        chk("r_ones", int'(r_ones), ero);
        chk("err_out", int'(err_out), ee);
        chk("busy_at_done", int'(busy), 0);
    endtask

    initial begin
        int k;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;

        repeat (10) begin
            @(negedge clk);
            chk("idle_busy", int'(busy), 0);
            chk("idle_done", int'(done), 0);
        end
        chk("rst_q_tens", int'(q_tens), 0);
        chk("rst_r_ones", int'(r_ones), 0);
        chk("rst_err_out", int'(err_out), 0);

        do_conv(4'd13, 4'd7, 1'b0, 1, 3, 0, 7, 0);
        @(negedge clk);
        chk("done_one_cycle", int'(done), 0);
        do_conv(4'd15, 4'd0, 1'b0, 1, 5, 0, 0, 0);
        do_conv(4'd0, 4'd15, 1'b0, 0, 0, 1, 5, 0);
        do_conv(4'd9, 4'd10, 1'b0, 0, 9, 1, 0, 0);

        do_conv(4'd15, 4'd15, 1'b1, 14, 14, 14, 14, 1);
        @(negedge clk);
        do_conv(4'd2, 4'd1, 1'b0, 0, 2, 0, 1, 0);
        @(negedge clk);

        // Start again while busy, with new operands held afterwards.
        Q = 4'd5;
        R = 4'd3;
        ERR = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        Q = 4'd12;
        R = 4'd11;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 2;
        while (!done && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk("busy_start_latency", k, 4);
        chk("busy_start_q_ones", int'(q_ones), 5);
        chk("busy_start_r_ones", int'(r_ones), 3);
        chk("busy_start_q_tens", int'(q_tens), 0);
        // Back-to-back start in the done cycle.
        do_conv(4'd12, 4'd11, 1'b0, 1, 2, 1, 1, 0);
        @(negedge clk);

        // Reset during conversion.
        Q = 4'd11;
        R = 4'd4;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_q_tens", int'(q_tens), 0);
        chk("abort_r_tens", int'(r_tens), 0);
        chk("abort_r_ones", int'(r_ones), 0);
        repeat (6) begin
            @(negedge clk);
            chk("abort_no_done", int'(done), 0);
        end
        do_conv(4'd11, 4'd4, 1'b0, 1, 1, 0, 4, 0);
        @(negedge clk);

        // Reset and start on the same edge: start is dropped.
        rst = 1'b1;
        start = 1'b1;
        Q = 4'd7;
        R = 4'd7;
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        chk("rst_start_busy", int'(busy), 0);
        repeat (6) begin
            @(negedge clk);
            chk("rst_start_no_done", int'(done), 0);
        end
        chk("rst_start_q_ones", int'(q_ones), 0);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/div_result_bcd.md
Name: div_result_bcd

Overview:
- Sequential stage directly downstream of the 4-bit combinational divider.
- On a start strobe, captures the divider's quotient, remainder and error flag.
- Converts quotient and remainder, in parallel, into two-digit BCD using a 4-iteration shift-and-add-3 (double dabble).
- Presents registered digits plus an error indication to the display/decoder stage, with a busy/done handshake.

Parameters:
ERR_CODE, 4'hE, value driven on all four digit outputs when the captured error flag is 1.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
start  input  1  capture request; sampled only in IDLE
Q  input  4  divider quotient (unsigned 0..15)
R  input  4  divider remainder (unsigned 0..15)
ERR  input  1  divider divide-by-zero flag
busy  output  1  high while a conversion is in progress
done  output  1  one-cycle pulse when outputs are updated
q_tens  output  4  quotient tens digit (BCD)
q_ones  output  4  quotient ones digit (BCD)
r_tens  output  4  remainder tens digit (BCD)
r_ones  output  4  remainder ones digit (BCD)
err_out  output  1  registered copy of captured ERR

Behaviour:
- One clock; reset is synchronous and active-high. Outputs and state are cleared only when rst is high at a rising clk edge.
- Reset values: busy=0, done=0, all digit outputs 4'h0, err_out=0, FSM=IDLE, iteration counter=0, internal shift registers 0.
- FSM states: IDLE, CONV, FINISH.
- IDLE:
  - start=1 at edge E0 latches Q, R and ERR into internal registers.
  - BCD accumulators clear; counter=0; busy=1 after E0; next state CONV.
  - start=0: remain in IDLE, outputs hold.
- CONV, edges E1..E3: one double-dabble iteration per edge on each operand independently:
  - add 3 to any BCD nibble >=5;
  - then shift left 1, MSB of the binary operand entering the ones nibble LSB.
  - Counter increments each edge; after the 3rd iteration, next state FINISH.
- FINISH, edge E4:
  - Performs the 4th iteration and loads the digit outputs.
  - If captured ERR=1, all four digit outputs load ERR_CODE instead of the conversion result.
  - err_out loads captured ERR.
  - done=1 for the cycle after E4 only; busy=0 after E4; next state IDLE.
- Latency:
  - Fixed 4 clocks from the start-sampling edge to the done-asserting edge, independent of operand values and ERR.
  - Back-to-back: start may be high in the cycle done is high and is accepted at E5.
- start while busy=1 is ignored; no queuing, captured operands are unaffected by later changes on Q/R/ERR.
- Digit outputs and err_out change only at the FINISH edge or reset; they hold between conversions, including while busy.
- Range:
  - Inputs 0..15 give tens in {0,1} and ones in 0..9.
  - Tens nibble bits [3:1] are always 0 for valid operands.
  - Internal BCD accumulator per operand is 8 bits; no overflow possible.
- rst=1 mid-conversion (any state) returns to IDLE with reset values on the next edge. The aborted conversion never produces done.
- rst and start both high on the same edge: reset wins, start is dropped.

Test Plan:
- Reset then idle: assert rst 2 cycles, hold start=0 for 10 cycles -> busy=0, done=0, all digits 0, err_out=0 throughout.
- Basic conversion: Q=4'd13, R=4'd7, ERR=0, start pulse at E0 -> done high exactly in the cycle after E4, q_tens=1, q_ones=3, r_tens=0, r_ones=7, err_out=0, busy high for cycles E0..E4.
- Boundaries: (Q=15,R=0) -> 1,5,0,0; (Q=0,R=15) -> 0,0,1,5; (Q=9,R=10) -> 0,9,1,0; each with latency 4.
- Divide-by-zero: ERR=1, Q=15, R=15, start -> after 4 cycles all digits 4'hE, err_out=1, done one cycle. Then a valid conversion Q=2,R=1 clears err_out to 0 and shows 0,2,0,1.
- Start while busy and input change: start at E0 with Q=5,R=3; pulse start again at E2 with Q=12,R=11 and hold those inputs -> single done, digits 0,5,0,3. Back-to-back start in the done cycle is accepted, and 4 cycles later shows 1,2,1,1.
- Reset mid-operation: start with Q=11,R=4, assert rst at E2 -> no done pulse, outputs return to 0 next edge, busy=0. A fresh start afterwards converts normally with latency 4.
